axi_read_arbiter: RTL
=====================

# axi_read_arbiter

Shares the single AXI read address/data channel pair among the three read requesters of the CPU: instruction cache refill, data cache refill, and uncached data loads. Sits between the caches and the AXI master port, alongside the write path. One transaction is outstanding at a time. Beats are assembled into a 128-bit line for cache refills, and the result is returned to the requester that won arbitration.

## Interface
- ICACHE_ID, 4'd0, arid used for instruction requests
- DCACHE_ID, 4'd1, arid used for data cache refills
- UNCACHE_ID, 4'd2, arid used for uncached loads
- LINE_BEATS, 4, 32-bit beats per cache line (arlen = LINE_BEATS-1)

Ports:
- clk  in  1  the only clock
- reset  in  1  asynchronous, active-high
- icache_req / icache_uncache / icache_addr  in  1/1/32  instruction read request; uncached flag; byte address
- icache_addr_ready  out  1  request accepted (one-cycle pulse)
- icache_data_ready / icache_rdata  out  1/128  return pulse; line, or word in [31:0] if uncached
- dcache_rd_req / dcache_rd_addr  in  1/32  data line refill request
- dcache_rd_rdy  out  1  accept pulse
- dcache_ret_valid / dcache_ret_data  out  1/128  return pulse; line
- uncache_rd_req / uncache_rd_size / uncache_rd_addr  in  1/3/32  uncached load; AXI size code; address
- uncache_rd_rdy  out  1  accept pulse
- uncache_ret_valid / uncache_ret_data  out  1/32  return pulse; word
- arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot  out  4,32,8,3,2,2,4,3  AXI AR fields
- arvalid  out  1;  arready  in  1
- rid, rdata, rresp, rlast, rvalid  in  4,32,2,1,1  AXI R fields
- rready  out  1

## Operation
- States: IDLE, AR, R, RET.
- IDLE
  - Fixed priority: uncache > dcache > icache.
  - The winner's *_rdy is driven combinationally high in the same cycle its req is seen.
  - Latch source, address, length and size; go to AR.
- Per-source AR fields:
  - Cached (dcache, or icache with icache_uncache=0): araddr = {addr[31:4],4'b0}, arlen=3, arsize=2.
  - icache uncached: araddr = addr, arlen=0, arsize=2.
  - uncache: araddr = addr, arlen=0, arsize=uncache_rd_size.
- Constant AR fields: arburst=2'b01, arlock=0, arcache=0, arprot=0.
- AR: arvalid=1 with all AR fields held stable; on arready go to R, clear the beat counter.
- R: rready=1.
  - A beat counts only when rvalid=1 and rid matches the latched id; other beats are ignored.
  - An accepted beat is written to line word [cnt] and cnt increments, saturating at LINE_BEATS-1.
  - A beat with rlast=1 goes to RET, even if fewer beats than expected arrived (unfilled words keep old values).
- RET: the winner's return-valid is high for exactly one cycle, with data from the registered line buffer (word 0 for single-beat requests); then go to IDLE.
- rresp is ignored; error data passes through unchanged.
- A requester whose req is held during another's transaction waits; no request is lost or accepted twice.

## Timing
- Reset values (async on reset high): state=IDLE, arvalid=0, rready=0, all *_rdy/*_valid=0, line buffer=0, AR fields=0.
- Reset mid-transaction returns to IDLE immediately; the pending AXI transaction is abandoned.
- Latency with zero-wait slave:
  - accept at cycle 0, arvalid at cycle 1, arready at cycle 1, first beat at cycle 2.
  - cached line: rlast at cycle 5, return pulse at cycle 6.
  - single beat: return pulse at cycle 3.
- Next accept is possible at the IDLE cycle after RET (cycle 7 for a line).
- All outputs except *_rdy are registered. arvalid never drops before arready.

## Structure
- Shared package (cpu_defs): AXI burst/size constants, source id constants, and the arbiter state enum `rd_arb_state_t`.
- One natural sub-module: `axi_rd_line_buffer`, a beat counter plus 4×32 line register with write enable, clear, and rlast-done output.

## Test plan
- icache req at 0x1FC0_0004, cached, beats 0xA,0xB,0xC,0xD -> araddr 0x1FC0_0000, arlen 3, arid 0; icache_rdata = 0x0000000D_0000000C_0000000B_0000000A, one-cycle pulse.
- uncache, dcache and icache requests all high in the same cycle -> served in order uncache (arid 2), dcache (arid 1), icache (arid 0), one transaction at a time.
- uncache load at 0xBFAF_8000, size 2, rdata 0x1234_5678 -> arlen 0, arsize 2; uncache_ret_data 0x1234_5678 at cycle 3.
- arready held low 5 cycles -> arvalid and araddr stay stable; rvalid with rid=3 -> beat ignored, no return pulse.
- reset asserted during the R state of a dcache refill -> all outputs 0 asynchronously; after reset, a new dcache req is accepted normally.
- rlast on beat 2 of a line -> return pulse next cycle; words 0–1 hold the new data, words 2–3 keep their previous values.

Source files
------------

// File: rtl/axi_read_arbiter_pkg.sv
// Shared CPU definitions used by the AXI read arbiter and its line buffer.
// Contents:
//   - AXI source ids (arid values) for the three read requesters
//   - cache line geometry (beats per line, beat counter width, arlen values)
//   - AXI burst/size constants
//   - arbiter FSM state enum and the requester (source) enum
package cpu_defs;

    localparam logic [3:0] ICACHE_ID    = 4'd0;
    localparam logic [3:0] DCACHE_ID    = 4'd1;
    localparam logic [3:0] UNCACHE_ID   = 4'd2;

    localparam int         LINE_BEATS   = 4;
    localparam int         BEAT_CNT_W   = $clog2(LINE_BEATS);
    localparam logic [7:0] LINE_ARLEN   = 8'(LINE_BEATS - 1);
    localparam logic [7:0] SINGLE_ARLEN = 8'd0;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'd2;

    typedef enum logic [1:0] {
        IDLE,
        AR,
        R,
        RET
    } rd_arb_state_t;

    typedef enum logic [1:0] {
        SRC_ICACHE,
        SRC_DCACHE,
        SRC_UNCACHE
    } rd_src_t;

endpackage

// File: rtl/axi_read_arbiter_if.sv
// AXI read address (AR) and read data (R) channel bundle.
// Ports (signals):
//   AR: arid[3:0], araddr[31:0], arlen[7:0], arsize[2:0], arburst[1:0],
//       arlock[1:0], arcache[3:0], arprot[2:0], arvalid, arready
//   R : rid[3:0], rdata[31:0], rresp[1:0], rlast, rvalid, rready
// Modports:
//   master - the arbiter side (drives AR and rready)
//   slave  - the memory/interconnect side
interface axi_read_arbiter_if;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/axi_read_arbiter_line_buffer.sv
// Beat counter plus LINE_BEATS x 32-bit line register for assembling read bursts.
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   clear        restart the beat counter at word 0 (line contents are kept)
//   we           accept one beat: write wdata into word [cnt] and advance cnt
//   wdata[31:0]  beat data
//   wlast        the beat being written is the last of the burst
//   line[127:0]  registered line, word 0 in bits [31:0]
//   done         a last beat is being written this cycle
module axi_rd_line_buffer
    import cpu_defs::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        we,
    input  logic [31:0]                 wdata,
    input  logic                        wlast,
    output logic [LINE_BEATS*32-1:0]    line,
    output logic                        done
);

    localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(LINE_BEATS - 1);

    logic [BEAT_CNT_W-1:0]        cnt;
    logic [LINE_BEATS-1:0][31:0]  words;

    // Beats land in consecutive words. The counter sticks at the last word so
    // an over-long burst keeps overwriting the top word instead of wrapping
    // back onto word 0. Words not reached by a short burst keep old data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            words <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (we) begin
            words[cnt] <= wdata;
            if (cnt != LAST_BEAT) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign line = words;
    assign done = we & wlast;

endmodule

// File: rtl/axi_read_arbiter.sv
// Arbitrates the single AXI read channel among instruction cache refill,
// data cache refill and uncached loads; one transaction outstanding.
// Ports:
//   clk, reset                          clock, asynchronous active-high reset
//   icache_req/uncache/addr             instruction read request
//   icache_addr_ready                   combinational accept pulse
//   icache_data_ready/icache_rdata      return pulse; line, or word in [31:0] if uncached
//   dcache_rd_req/addr, dcache_rd_rdy   data cache line refill request / accept
//   dcache_ret_valid/data               return pulse; line
//   uncache_rd_req/size/addr, _rdy      uncached load request / accept
//   uncache_ret_valid/data              return pulse; word
//   axi                                 AXI AR/R channels (master side)
module axi_read_arbiter
    import cpu_defs::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                icache_req,
    input  logic                icache_uncache,
    input  logic [31:0]         icache_addr,
    output logic                icache_addr_ready,
    output logic                icache_data_ready,
    output logic [127:0]        icache_rdata,
    input  logic                dcache_rd_req,
    input  logic [31:0]         dcache_rd_addr,
    output logic                dcache_rd_rdy,
    output logic                dcache_ret_valid,
    output logic [127:0]        dcache_ret_data,
    input  logic                uncache_rd_req,
    input  logic [2:0]          uncache_rd_size,
    input  logic [31:0]         uncache_rd_addr,
    output logic                uncache_rd_rdy,
    output logic                uncache_ret_valid,
    output logic [31:0]         uncache_ret_data,
    axi_read_arbiter_if.master  axi
);

    rd_arb_state_t state, next_state;
    rd_src_t       src, sel_src;
    logic          ic_single, sel_ic_single;
    logic          accept;
    logic [3:0]    sel_id;
    logic [31:0]   sel_addr;
    logic [7:0]    sel_len;
    logic [2:0]    sel_size;
    logic          beat_we, beat_clear, line_done;
    logic [127:0]  line;
    logic          unused_bits;

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state plus the combinational accept pulses. In IDLE the highest
    // priority requester (uncache > dcache > icache) wins and its AR fields
    // are selected here so the registers can capture them on the accept edge.
    // Cached reads fetch the whole aligned line; uncached reads a single beat.
    always_comb begin
        next_state        = state;
        accept            = 1'b0;
        icache_addr_ready = 1'b0;
        dcache_rd_rdy     = 1'b0;
        uncache_rd_rdy    = 1'b0;
        sel_src           = SRC_ICACHE;
        sel_ic_single     = 1'b0;
        sel_id            = ICACHE_ID;
        sel_addr          = '0;
        sel_len           = SINGLE_ARLEN;
        sel_size          = AXI_SIZE_4B;
        case (state)
            IDLE: begin
                if (uncache_rd_req) begin
                    uncache_rd_rdy = 1'b1;
                    accept         = 1'b1;
                    sel_src        = SRC_UNCACHE;
                    sel_id         = UNCACHE_ID;
                    sel_addr       = uncache_rd_addr;
                    sel_size       = uncache_rd_size;
                end else if (dcache_rd_req) begin
                    dcache_rd_rdy  = 1'b1;
                    accept         = 1'b1;
                    sel_src        = SRC_DCACHE;
                    sel_id         = DCACHE_ID;
                    sel_addr       = {dcache_rd_addr[31:4], 4'b0};
                    sel_len        = LINE_ARLEN;
                end else if (icache_req) begin
                    icache_addr_ready = 1'b1;
                    accept            = 1'b1;
                    sel_ic_single     = icache_uncache;
                    sel_addr          = icache_uncache ? icache_addr : {icache_addr[31:4], 4'b0};
                    sel_len           = icache_uncache ? SINGLE_ARLEN : LINE_ARLEN;
                end
                if (accept) begin
                    next_state = AR;
                end
            end
            AR: begin
                if (axi.arready) begin
                    next_state = R;
                end
            end
            R: begin
                if (line_done) begin
                    next_state = RET;
                end
            end
            RET: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Registered AXI and return outputs. AR fields are captured at accept and
    // held until the next accept, so they stay stable while arvalid waits for
    // arready. The return pulse is raised on the edge that takes the last
    // beat, which makes it coincide with the RET state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            axi.arid          <= '0;
            axi.araddr        <= '0;
            axi.arlen         <= '0;
            axi.arsize        <= '0;
            axi.arburst       <= '0;
            axi.arlock        <= '0;
            axi.arcache       <= '0;
            axi.arprot        <= '0;
            axi.arvalid       <= 1'b0;
            axi.rready        <= 1'b0;
            src               <= SRC_ICACHE;
            ic_single         <= 1'b0;
            icache_data_ready <= 1'b0;
            dcache_ret_valid  <= 1'b0;
            uncache_ret_valid <= 1'b0;
        end else begin
            icache_data_ready <= 1'b0;
            dcache_ret_valid  <= 1'b0;
            uncache_ret_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        axi.arid    <= sel_id;
                        axi.araddr  <= sel_addr;
                        axi.arlen   <= sel_len;
                        axi.arsize  <= sel_size;
                        axi.arburst <= AXI_BURST_INCR;
                        axi.arlock  <= '0;
                        axi.arcache <= '0;
                        axi.arprot  <= '0;
                        axi.arvalid <= 1'b1;
                        src         <= sel_src;
                        ic_single   <= sel_ic_single;
                    end
                end
                AR: begin
                    if (axi.arready) begin
                        axi.arvalid <= 1'b0;
                        axi.rready  <= 1'b1;
                    end
                end
                R: begin
                    if (line_done) begin
                        axi.rready <= 1'b0;
                        case (src)
                            SRC_ICACHE:  icache_data_ready <= 1'b1;
                            SRC_DCACHE:  dcache_ret_valid  <= 1'b1;
                            SRC_UNCACHE: uncache_ret_valid <= 1'b1;
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    // Only beats tagged with our own id belong to the outstanding transaction.
    assign beat_clear = (state == AR) && axi.arready;
    assign beat_we    = (state == R) && axi.rvalid && (axi.rid == axi.arid);

    axi_rd_line_buffer u_line_buffer (
        .clk   (clk),
        .reset (reset),
        .clear (beat_clear),
        .we    (beat_we),
        .wdata (axi.rdata),
        .wlast (axi.rlast),
        .line  (line),
        .done  (line_done)
    );

    assign icache_rdata     = ic_single ? {96'b0, line[31:0]} : line;
    assign dcache_ret_data  = line;
    assign uncache_ret_data = line[31:0];

    // Read responses are passed through regardless of rresp, and dcache
    // refills are always line aligned, so these bits carry no information.
    assign unused_bits = ^{axi.rresp, dcache_rd_addr[3:0]};

endmodule
